// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code monitor: FSM state encoding and
// the Gray-to-binary decode used by gray_monitor.
package gray_pkg;

    localparam int DEF_GW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    // bin[i] is the XOR of g[w-1:i]; bits at or above w stay zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] b;
        logic        acc;
        b   = 32'd0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            acc  = acc ^ (g[i] & (i < w));
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Two-flop synchronizer for the Gray/Overflow inputs when they arrive from
// another clock domain.
module gray_sync #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture chain.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/gray_monitor.sv
// Checks a Gray-code counter stream for legal single-step increments and
// extends it with a wrap counter. Build option GRAY_SYNC_EN adds an input synchronizer.
module gray_monitor
    import gray_pkg::*;
#(
    parameter int GW    = 3,
    parameter int EXT_W = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Valid,
    input  logic [GW-1:0]       Gray,
    input  logic                Overflow_in,
    input  logic                Clear,
    output logic [GW-1:0]       Bin,
    output logic [EXT_W+GW-1:0] Count,
    output logic                WrapPulse,
    output logic                ExtOvf,
    output logic                Error,
    output logic [1:0]          State
);

    localparam logic [GW-1:0] ONE  = GW'(1);
    localparam logic [GW-1:0] MAXV = '1;

    logic [GW-1:0] gray_s;
    logic          ovf_s;
    logic          valid_s;

`ifdef GRAY_SYNC_EN
    logic [GW:0] sync_s;

    gray_sync #(.W(GW + 1)) u_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     ({Overflow_in, Gray}),
        .q     (sync_s)
    );

    assign gray_s  = sync_s[GW-1:0];
    assign ovf_s   = sync_s[GW];
    assign valid_s = 1'b1;
`else
    assign gray_s  = Gray;
    assign ovf_s   = Overflow_in;
    assign valid_s = Valid;
`endif

    state_t           state_r;
    logic [GW-1:0]    prev_r;
    logic             prev_ovf_r;
    logic [GW-1:0]    bin_r;
    logic [EXT_W-1:0] wrap_r;
    logic             wrap_pulse_r;
    logic             ext_ovf_r;
    logic             error_r;

    logic [31:0]   dec_full_s;
    logic [GW-1:0] diff_s;
    logic [GW-1:0] inc_s;
    logic          one_bit_s;
    logic          legal_s;
    logic          wrap_s;
    logic          ovf_rise_s;
    logic          bad_s;

    assign dec_full_s = gray2bin({{(32-GW){1'b0}}, gray_s}, GW);
    assign diff_s     = gray_s ^ prev_r;
    assign inc_s      = bin_r + ONE;
    assign one_bit_s  = (diff_s != '0) && ((diff_s & (diff_s - ONE)) == '0);
    assign legal_s    = one_bit_s && (dec_full_s == {{(32-GW){1'b0}}, inc_s});
    assign wrap_s     = legal_s && (bin_r == MAXV);
    // An upstream overflow edge is only expected on the very step that wraps.
    assign ovf_rise_s = ovf_s & ~prev_ovf_r;
    assign bad_s      = ((diff_s != '0) && !legal_s) || (ovf_rise_s && !wrap_s);

    // Tracking FSM with all outputs registered.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            prev_r       <= '0;
            prev_ovf_r   <= 1'b0;
            bin_r        <= '0;
            wrap_r       <= '0;
            wrap_pulse_r <= 1'b0;
            ext_ovf_r    <= 1'b0;
            error_r      <= 1'b0;
        end else if (Clear) begin
            state_r      <= ST_IDLE;
            prev_r       <= '0;
            prev_ovf_r   <= 1'b0;
            bin_r        <= '0;
            wrap_r       <= '0;
            wrap_pulse_r <= 1'b0;
            ext_ovf_r    <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            wrap_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_s) begin
                        prev_r     <= gray_s;
                        bin_r      <= dec_full_s[GW-1:0];
                        prev_ovf_r <= ovf_s;
                        state_r    <= ST_TRACK;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_TRACK: begin
                    if (valid_s) begin
                        prev_ovf_r <= ovf_s;
                        if (bad_s) begin
                            error_r <= 1'b1;
                            state_r <= ST_ERROR;
                        end else if (legal_s) begin
                            prev_r <= gray_s;
                            bin_r  <= inc_s;
                            if (wrap_s) begin
                                wrap_r       <= wrap_r + {{(EXT_W-1){1'b0}}, 1'b1};
                                wrap_pulse_r <= 1'b1;
                                if (&wrap_r) begin
                                    ext_ovf_r <= 1'b1;
                                end else begin
                                    ext_ovf_r <= ext_ovf_r;
                                end
                            end else begin
                                wrap_r <= wrap_r;
                            end
                        end else begin
                            prev_r <= prev_r;
                        end
                    end else begin
                        state_r <= ST_TRACK;
                    end
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Bin       = bin_r;
    assign Count     = {wrap_r, bin_r};
    assign WrapPulse = wrap_pulse_r;
    assign ExtOvf    = ext_ovf_r;
    assign Error     = error_r;
    assign State     = state_r;

endmodule
